axis_arb_mux: RTL and testbench

- Single-clock AXI-stream N:1 arbitrating multiplexer.
- Successor to the fixed-priority fan-in. Adds:
  - selectable fixed-priority or round-robin arbitration
  - packet lock on tlast
  - optional burst cap when tlast is unused
  - per-channel tuser passthrough
  - binary channel ID output
  - full-throughput skid-buffered output
- Sits between per-channel DSP/capture streams and a shared DMA/packetiser.

---
 rtl/axis_arb_mux_pkg.sv | 38 +++
 rtl/axis_skid_buf.sv | 57 +++++
 rtl/axis_arb_mux.sv | 149 ++++++++++++++
 tb/tb_axis_arb_mux.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_mux_pkg.sv
// ----------------------------------------------------------------------------
// axis_arb_mux_pkg : shared constants, FSM encoding and width helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package axis_arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int chan_id_width(input int n);
    return (n <= 2) ? 1 : log2_ceil(n);
  endfunction

  // MAX_BURST=0 (unlimited) still needs a one-bit counter to exist
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : log2_ceil(max_burst + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buf.sv
// ----------------------------------------------------------------------------
// axis_skid_buf : 2-entry valid/ready skid buffer, registered input ready
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (i_valid && !r_skid_valid) begin
      // Park the beat in the skid slot only when the output is stalled
      if (!r_out_valid || i_ready) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
      end
    end else if (r_out_valid && i_ready) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_arb_mux.sv
// ----------------------------------------------------------------------------
// axis_arb_mux : N:1 AXI-stream arbitrating mux with packet lock and skid output
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axis_arb_mux
  import axis_arb_mux_pkg::*;
#(
  parameter int NUM_CHAN       = 6,
  parameter int DATA_WIDTH     = 256,
  parameter int USER_WIDTH     = 8,
  parameter int ARB_MODE       = 1,
  parameter int USE_AXIS_TLAST = 1,
  parameter int MAX_BURST      = 16
) (
  input  logic                             axis_clk,
  input  logic                             axis_rstn,
  input  logic [NUM_CHAN-1:0]              s_axis_tvalid,
  output logic [NUM_CHAN-1:0]              s_axis_tready,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CHAN*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_CHAN-1:0]              s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic [chan_id_width(NUM_CHAN)-1:0] m_axis_tid
);

  localparam int CW   = chan_id_width(NUM_CHAN);
  localparam int CW_B = burst_cnt_width(MAX_BURST);
  localparam int PW   = DATA_WIDTH + USER_WIDTH + 1 + CW;

  arb_state_t      r_state, w_state_nxt;
  logic [CW-1:0]   r_grant, w_grant_nxt;
  logic [CW-1:0]   r_ptr, w_ptr_nxt;
  logic [CW_B-1:0] r_burst, w_burst_nxt;
  logic [CW-1:0]   w_pick;
  logic            w_pick_vld;
  logic [CW:0]     w_sum;
  logic [CW-1:0]   w_idx;
  logic            w_skid_ready;
  logic            w_xfer;
  logic            w_release;
  logic            w_sel_last;
  logic [PW-1:0]   w_beat;
  logic [PW-1:0]   w_mbeat;

  logic [DATA_WIDTH-1:0] w_chan_data [NUM_CHAN];
  logic [USER_WIDTH-1:0] w_chan_user [NUM_CHAN];

  for (genvar n = 0; n < NUM_CHAN; n++) begin : g_unpack
    assign w_chan_data[n] = s_axis_tdata[n*DATA_WIDTH +: DATA_WIDTH];
    assign w_chan_user[n] = s_axis_tuser[n*USER_WIDTH +: USER_WIDTH];
  end

  // Scan starts at ptr in round-robin mode, at 0 in fixed mode
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (ARB_MODE == ARB_RR) begin
        w_sum = {1'b0, r_ptr} + (CW+1)'(i);
        if (w_sum >= (CW+1)'(NUM_CHAN)) w_sum = w_sum - (CW+1)'(NUM_CHAN);
      end else begin
        w_sum = (CW+1)'(i);
      end
      w_idx = w_sum[CW-1:0];
      if (!w_pick_vld && s_axis_tvalid[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_xfer     = (r_state == ST_LOCK) && s_axis_tvalid[r_grant] && w_skid_ready;
  assign w_sel_last = (USE_AXIS_TLAST != 0) ? s_axis_tlast[r_grant] : 1'b0;

  if (USE_AXIS_TLAST != 0) begin : g_rel_tlast
    assign w_release = w_xfer && s_axis_tlast[r_grant];
  end else if (MAX_BURST > 0) begin : g_rel_cap
    assign w_release = (w_xfer && (r_burst == CW_B'(MAX_BURST - 1))) || !s_axis_tvalid[r_grant];
  end else begin : g_rel_nocap
    assign w_release = !s_axis_tvalid[r_grant];
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_burst_nxt   = r_burst;
    s_axis_tready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_LOCK;
          w_grant_nxt = w_pick;
          w_burst_nxt = '0;
          w_ptr_nxt   = (w_pick == CW'(NUM_CHAN - 1)) ? '0 : w_pick + CW'(1);
        end
      end
      ST_LOCK: begin
        s_axis_tready[r_grant] = w_skid_ready;
        if (w_xfer && (r_burst != {CW_B{1'b1}})) w_burst_nxt = r_burst + CW_B'(1);
        if (w_release) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  assign w_beat = {w_chan_data[r_grant], w_chan_user[r_grant], w_sel_last, r_grant};

  axis_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (axis_clk),
    .rstn    (axis_rstn),
    .i_valid (w_xfer),
    .o_ready (w_skid_ready),
    .i_data  (w_beat),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready),
    .o_data  (w_mbeat)
  );

  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tid} = w_mbeat;

endmodule

`default_nettype wire

// File: tb/tb_axis_arb_mux.sv
// ----------------------------------------------------------------------------
// tb_axis_arb_mux : scoreboard bench for RR, fixed-priority and burst-cap muxes
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axis_arb_mux;
  import axis_arb_mux_pkg::*;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int UW = 8;
  localparam int ND = 3;

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
    logic          first;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn     [ND];
  logic [NC-1:0]     s_tvalid [ND];
  logic [NC-1:0]     s_tready [ND];
  logic [NC-1:0]     s_tlast  [ND];
  logic [NC*DW-1:0]  s_tdata  [ND];
  logic [NC*UW-1:0]  s_tuser  [ND];
  logic              m_tvalid [ND];
  logic              m_tready [ND];
  logic              m_tlast  [ND];
  logic [DW-1:0]     m_tdata  [ND];
  logic [UW-1:0]     m_tuser  [ND];
  logic [1:0]        m_tid    [ND];

  beat_t src_q [ND][NC][$];
  beat_t exp_q [ND][$];
  logic  bp      [ND];
  logic  chk_gap [ND];
  int    cyc     [ND];
  int    prev_cyc[ND];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int ch, input int pkt, input int b, input bit last, input bit first);
    beat_t x;
    x.ch    = 2'(ch);
    x.data  = {4'(ch), 4'(pkt), 8'(b)};
    x.user  = 8'(ch * 37 + pkt * 11 + b * 3) ^ 8'hA5;
    x.last  = last;
    x.first = first;
    return x;
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int MODE = (k == 1) ? ARB_FIXED : ARB_RR;
    localparam int TL   = (k == 2) ? 0 : 1;

    axis_arb_mux #(
      .NUM_CHAN       (NC),
      .DATA_WIDTH     (DW),
      .USER_WIDTH     (UW),
      .ARB_MODE       (MODE),
      .USE_AXIS_TLAST (TL),
      .MAX_BURST      (4)
    ) u_dut (
      .axis_clk      (clk),
      .axis_rstn     (rstn[k]),
      .s_axis_tvalid (s_tvalid[k]),
      .s_axis_tready (s_tready[k]),
      .s_axis_tdata  (s_tdata[k]),
      .s_axis_tuser  (s_tuser[k]),
      .s_axis_tlast  (s_tlast[k]),
      .m_axis_tvalid (m_tvalid[k]),
      .m_axis_tready (m_tready[k]),
      .m_axis_tdata  (m_tdata[k]),
      .m_axis_tuser  (m_tuser[k]),
      .m_axis_tlast  (m_tlast[k]),
      .m_axis_tid    (m_tid[k])
    );

    // Source driver: holds each channel's queue head until it is accepted
    initial begin : p_drv
      logic [NC-1:0] hs;
      beat_t h;
      s_tvalid[k] = '0;
      s_tdata[k]  = '0;
      s_tuser[k]  = '0;
      s_tlast[k]  = '0;
      m_tready[k] = 1'b1;
      forever begin
        @(negedge clk);
        hs = s_tvalid[k] & s_tready[k];
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
          if (hs[c] && src_q[k][c].size() > 0) void'(src_q[k][c].pop_front());
          if (src_q[k][c].size() > 0) begin
            h = src_q[k][c][0];
            s_tvalid[k][c]          = 1'b1;
            s_tdata[k][c*DW +: DW]  = h.data;
            s_tuser[k][c*UW +: UW]  = h.user;
            s_tlast[k][c]           = h.last;
          end else begin
            s_tvalid[k][c]          = 1'b0;
            s_tdata[k][c*DW +: DW]  = '0;
            s_tuser[k][c*UW +: UW]  = '0;
            s_tlast[k][c]           = 1'b0;
          end
        end
        m_tready[k] = bp[k] ? ~m_tready[k] : 1'b1;
      end
    end

    // Monitor: compares every output handshake against the scoreboard
    initial begin : p_mon
      beat_t e;
      logic held;
      logic [DW+UW+2:0] hv;
      held    = 1'b0;
      hv      = '0;
      cyc[k]  = 0;
      forever begin
        @(negedge clk);
        cyc[k]++;
        if (!rstn[k]) begin
          held = 1'b0;
        end else begin
          if (held)
            chk($sformatf("d%0d_stable", k),
                64'({m_tvalid[k], m_tdata[k], m_tuser[k], m_tlast[k], m_tid[k]}),
                64'({1'b1, hv}));
          if (m_tvalid[k] && m_tready[k]) begin
            held = 1'b0;
            if (exp_q[k].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL d%0d_extra_beat: got tid %0d data %0h, expected no beat",
                       k, m_tid[k], m_tdata[k]);
            end else begin
              e = exp_q[k].pop_front();
              chk($sformatf("d%0d_beat{tid,data,user,last}", k),
                  64'({m_tid[k], m_tdata[k], m_tuser[k], m_tlast[k]}),
                  64'({e.ch, e.data, e.user, e.last}));
              if (chk_gap[k] && prev_cyc[k] >= 0)
                chk($sformatf("d%0d_gap", k), 64'(cyc[k] - prev_cyc[k]), e.first ? 64'd2 : 64'd1);
              prev_cyc[k] = cyc[k];
            end
          end else if (m_tvalid[k]) begin
            held = 1'b1;
            hv   = {m_tdata[k], m_tuser[k], m_tlast[k], m_tid[k]};
          end else begin
            held = 1'b0;
          end
        end
      end
    end
  end

  task automatic drain(input int k, input int budget);
    int i;
    i = 0;
    while (exp_q[k].size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("d%0d_drain_left", k), 64'(exp_q[k].size()), 64'd0);
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic push(input int k, input beat_t b, input bit to_src, input bit to_exp);
    if (to_src) src_q[k][b.ch].push_back(b);
    if (to_exp) exp_q[k].push_back(b);
  endtask

  initial begin : p_main
    beat_t b;
    int i;
    for (int k = 0; k < ND; k++) begin
      rstn[k]     = 1'b0;
      bp[k]       = 1'b0;
      chk_gap[k]  = 1'b0;
      prev_cyc[k] = -1;
    end

    // Reset hold with every channel requesting
    for (int c = 0; c < NC; c++) push(0, mk(c, 0, 0, 1'b1, 1'b1), 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("rst_s_tready", 64'(s_tready[0]), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid[0]), 64'd0);
    end
    #2;
    for (int k = 0; k < ND; k++) rstn[k] = 1'b1;
    drain(0, 100);

    // Round-robin fairness, 3-beat packets on all channels
    prev_cyc[0] = -1;
    chk_gap[0]  = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NC; c++)
        for (int bt = 0; bt < 3; bt++)
          push(0, mk(c, p, bt, bt == 2, bt == 0), 1'b1, 1'b1);
    drain(0, 200);
    chk_gap[0] = 1'b0;

    // Backpressure 1010... over a 16-beat packet
    bp[0] = 1'b1;
    prev_cyc[0] = -1;
    for (int bt = 0; bt < 16; bt++) push(0, mk(1, 2, bt, bt == 15, bt == 0), 1'b1, 1'b1);
    drain(0, 200);
    bp[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2;

    // Mid-packet reset on a 10-beat packet
    for (int bt = 0; bt < 10; bt++) push(0, mk(0, 3, bt, bt == 9, bt == 0), 1'b1, 1'b1);
    i = 0;
    while (src_q[0][0].size() > 5 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("midrst_beats_taken", 64'(src_q[0][0].size()), 64'd5);
    #2;
    rstn[0] = 1'b0;
    for (int c = 0; c < NC; c++) src_q[0][c].delete();
    exp_q[0].delete();
    @(negedge clk);
    chk("midrst_m_outputs", 64'({m_tvalid[0], m_tdata[0], m_tuser[0], m_tlast[0], m_tid[0]}), 64'd0);
    chk("midrst_s_tready", 64'(s_tready[0]), 64'd0);
    @(negedge clk);
    #2;
    rstn[0]     = 1'b1;
    prev_cyc[0] = -1;
    for (int bt = 0; bt < 3; bt++) push(0, mk(2, 4, bt, bt == 2, bt == 0), 1'b1, 1'b1);
    drain(0, 100);

    // Fixed priority: ch0 starves ch2 until it goes idle
    prev_cyc[1] = -1;
    chk_gap[1]  = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int bt = 0; bt < 3; bt++)
        push(1, mk(0, p, bt, bt == 2, bt == 0), 1'b1, 1'b1);
    for (int p = 0; p < 2; p++)
      for (int bt = 0; bt < 2; bt++)
        push(1, mk(2, p, bt, bt == 1, bt == 0), 1'b1, 1'b1);
    drain(1, 200);
    chk_gap[1] = 1'b0;

    // Burst cap of 4 with tlast ignored, ch1 and ch3 streaming
    prev_cyc[2] = -1;
    chk_gap[2]  = 1'b1;
    for (int bt = 0; bt < 8; bt++) begin
      push(2, mk(1, 5, bt, bt % 2 == 1, 1'b0), 1'b1, 1'b0);
      push(2, mk(3, 5, bt, bt % 2 == 1, 1'b0), 1'b1, 1'b0);
    end
    for (int h = 0; h < 2; h++)
      for (int c = 1; c < NC; c += 2)
        for (int bt = h * 4; bt < h * 4 + 4; bt++) begin
          b = mk(c, 5, bt, 1'b0, bt % 4 == 0);
          push(2, b, 1'b0, 1'b1);
        end
    drain(2, 200);
    chk_gap[2] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
